// File: rtl/booth_mult_seq_pkg.sv
// Shared types for the sequential Booth multiplier: recoded operations, FSM states and
// the iteration-count helper used to size the step counter.
package booth_mult_seq_pkg;

   typedef enum logic [2:0] {
      OP_ZERO,
      OP_ADD_M,
      OP_SUB_M,
      OP_ADD_2M,
      OP_SUB_2M
   } booth_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Radix 2 retires one bit of the (WIDTH+1)-bit extended multiplier per step;
   // radix 4 retires two bits of that value padded to an even width.
   function automatic int unsigned iter_count(input int unsigned width, input int unsigned radix);
      int unsigned w1;
      int unsigned w2;
      w1 = width + 1;
      w2 = w1 + (w1 % 2);
      return (radix == 4) ? (w2 / 2) : w1;
   endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/product handshake bundle between the issuing stage and the Booth multiplier.
interface booth_mult_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 is_signed;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output in_valid, is_signed, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, is_signed, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/booth_recoder.sv
// Combinational Booth digit recoder: low multiplier bits (plus the bit shifted out last)
// to the add/subtract operation applied to the accumulator this step.
module booth_recoder
   import booth_mult_seq_pkg::*;
#(
   parameter int unsigned RADIX = 2
) (
   input  logic [2:0] bits_i,
   output booth_op_e  op_o
);

   if (RADIX == 4) begin : g_r4
      always_comb begin
         op_o = OP_ZERO;
         unique case (bits_i)
            3'b001, 3'b010: op_o = OP_ADD_M;
            3'b011:         op_o = OP_ADD_2M;
            3'b100:         op_o = OP_SUB_2M;
            3'b101, 3'b110: op_o = OP_SUB_M;
            default:        op_o = OP_ZERO;
         endcase
      end
   end else begin : g_r2
      logic unused_msb;
      assign unused_msb = bits_i[2];

      always_comb begin
         op_o = OP_ZERO;
         unique case (bits_i[1:0])
            2'b01:   op_o = OP_ADD_M;
            2'b10:   op_o = OP_SUB_M;
            default: op_o = OP_ZERO;
         endcase
      end
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2/4 Booth multiplier with operand and product handshakes; returns the
// exact 2*WIDTH-bit product of two signed or two unsigned operands.
module booth_mult_seq
   import booth_mult_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned RADIX = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   booth_mult_seq_if.slave  bus
);

   localparam int unsigned W1    = WIDTH + 1;
   localparam int unsigned W2    = W1 + (W1 % 2);
   localparam int unsigned ITER  = iter_count(WIDTH, RADIX);
   localparam int unsigned SHIFT = (RADIX == 4) ? 2 : 1;
   // Low field holds exactly the bits retired, so no multiplier bits remain at the end.
   localparam int unsigned LW    = (RADIX == 4) ? W2 : W1;
   localparam int unsigned ACC_W = W2 + 2;
   localparam int unsigned PW    = ACC_W + LW + 1;
   localparam int unsigned CW    = $clog2(ITER);

   if ((RADIX != 2) && (RADIX != 4)) begin : g_bad_radix
      $error("booth_mult_seq: RADIX must be 2 or 4");
   end
   if (WIDTH < 4) begin : g_bad_width
      $error("booth_mult_seq: WIDTH must be at least 4");
   end

   state_e               state_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [CW-1:0]        cnt_q;
   logic [PW-1:0]        p_q;
   logic [W1-1:0]        m_q;

   logic [W1-1:0]        a_ext;
   logic [LW-1:0]        b_ext;
   logic [ACC_W-1:0]     m_ext;
   logic [ACC_W-1:0]     h;
   logic [ACC_W-1:0]     h_sum;
   logic [PW-1:0]        p_sum;
   logic [PW-1:0]        p_step;
   booth_op_e            op;

   assign a_ext = {bus.is_signed & bus.multiplicand[WIDTH-1], bus.multiplicand};
   assign b_ext = {{(LW-WIDTH){bus.is_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier};
   assign m_ext = {{(ACC_W-W1){m_q[W1-1]}}, m_q};

   booth_recoder #(
      .RADIX (RADIX)
   ) u_recoder (
      .bits_i (p_q[2:0]),
      .op_o   (op)
   );

   always_comb begin
      h     = p_q[PW-1 -: ACC_W];
      h_sum = h;
      unique case (op)
         OP_ADD_M:  h_sum = h + m_ext;
         OP_SUB_M:  h_sum = h - m_ext;
         OP_ADD_2M: h_sum = h + (m_ext << 1);
         OP_SUB_2M: h_sum = h - (m_ext << 1);
         default:   h_sum = h;
      endcase
      p_sum  = {h_sum, p_q[LW:0]};
      p_step = $signed(p_sum) >>> SHIFT;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         product_q   <= '0;
         cnt_q       <= '0;
         p_q         <= '0;
         m_q         <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  m_q        <= a_ext;
                  p_q        <= {{ACC_W{1'b0}}, b_ext, 1'b0};
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= StRun;
               end
            end
            StRun: begin
               p_q   <= p_step;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(ITER - 1)) begin
                  product_q   <= p_step[2*WIDTH:1];
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q     <= StIdle;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;

endmodule
